// File: rtl/uart_in_responder.sv
// Console-input responder for the SimTop UART port: buffers host characters in a
// circular FIFO and answers core read requests combinationally, with event counters.
module uart_in_responder #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [7:0]  EMPTY_CH = 8'hff,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     host_valid,
  input  logic [7:0]               host_ch,
  output logic                     host_ready,
  input  logic                     flush,
  input  logic                     io_uart_in_valid,
  output logic [7:0]               io_uart_in_ch,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         rd_cnt,
  output logic [CNT_W-1:0]         empty_rd_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] empty_rd_cnt_q, empty_rd_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic full;
  logic not_empty;
  logic push;
  logic pop;
  logic empty_rd;
  logic drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Flush overrides every push/pop/count event in its cycle.
  always_comb begin
    full      = (level_q == LW'(DEPTH));
    not_empty = (level_q != '0);
    push      = host_valid && !full && !flush;
    pop       = io_uart_in_valid && not_empty && !flush;
    empty_rd  = io_uart_in_valid && !not_empty && !flush;
    drop      = host_valid && full && !flush;
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    rd_cnt_d       = rd_cnt_q;
    empty_rd_cnt_d = empty_rd_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        rd_cnt_d = sat_inc(rd_cnt_q);
      end
      if (empty_rd) empty_rd_cnt_d = sat_inc(empty_rd_cnt_q);
      if (drop)     drop_cnt_d     = sat_inc(drop_cnt_q);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      rd_cnt_q       <= '0;
      empty_rd_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      rd_cnt_q       <= rd_cnt_d;
      empty_rd_cnt_q <= empty_rd_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  // Storage array needs no reset; level gates every read of it.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= host_ch;
  end

  assign host_ready    = !full;
  assign io_uart_in_ch = not_empty ? mem_q[rd_ptr_q] : EMPTY_CH;
  assign level         = level_q;
  assign rd_cnt        = rd_cnt_q;
  assign empty_rd_cnt  = empty_rd_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_uart_in_responder.sv
// Bench for uart_in_responder: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_uart_in_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 32;

  logic             clock;
  logic             reset_n;
  logic             host_valid;
  logic [7:0]       host_ch;
  logic             host_ready;
  logic             flush;
  logic             io_uart_in_valid;
  logic [7:0]       io_uart_in_ch;
  logic [4:0]       level;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] empty_rd_cnt;
  logic [CNT_W-1:0] drop_cnt;

  int tests  = 0;
  int failed = 0;

  uart_in_responder #(.DEPTH(DEPTH), .EMPTY_CH(8'hff), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .host_valid(host_valid), .host_ch(host_ch), .host_ready(host_ready),
    .flush(flush), .io_uart_in_valid(io_uart_in_valid), .io_uart_in_ch(io_uart_in_ch),
    .level(level), .rd_cnt(rd_cnt), .empty_rd_cnt(empty_rd_cnt), .drop_cnt(drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a character queue and three saturating tallies.
  byte unsigned     m_q[$];
  logic [CNT_W-1:0] m_rd, m_empty, m_drop;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_rd = 0; m_empty = 0; m_drop = 0;
    end else if (flush) begin
      m_q.delete();
    end else begin
      bit was_full;
      was_full = (m_q.size() == DEPTH);
      if (io_uart_in_valid) begin
        if (m_q.size() != 0) begin
          void'(m_q.pop_front());
          m_rd = bump(m_rd);
        end else begin
          m_empty = bump(m_empty);
        end
      end
      if (host_valid) begin
        if (was_full) m_drop = bump(m_drop);
        else          m_q.push_back(host_ch);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("model_in_ch",      32'(io_uart_in_ch), (m_q.size() != 0) ? 32'(m_q[0]) : 32'hff);
    chk("model_host_ready", 32'(host_ready),    (m_q.size() != DEPTH) ? 32'd1 : 32'd0);
    chk("model_level",      32'(level),         32'(m_q.size()));
    chk("model_rd_cnt",     rd_cnt,             m_rd);
    chk("model_empty_cnt",  empty_rd_cnt,       m_empty);
    chk("model_drop_cnt",   drop_cnt,           m_drop);
  end

  task automatic step(input logic hv, input logic [7:0] ch, input logic rv, input logic fl);
    host_valid = hv; host_ch = ch; io_uart_in_valid = rv; flush = fl;
    @(posedge clock);
    #1;
    host_valid = 1'b0; io_uart_in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; host_valid = 1'b0; host_ch = 8'h00; flush = 1'b0; io_uart_in_valid = 1'b0;
    #1;
    chk("reset_host_ready", 32'(host_ready), 32'd1);
    chk("reset_in_ch", 32'(io_uart_in_ch), 32'hff);
    #22 reset_n = 1'b1;
    @(posedge clock); #1;

    // 1: reads of an empty FIFO
    for (int i = 0; i < 3; i++) begin
      chk("t1_in_ch_empty", 32'(io_uart_in_ch), 32'hff);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t1_empty_rd_cnt", empty_rd_cnt, 32'd3);
    chk("t1_rd_cnt", rd_cnt, 32'd0);

    // 2: "hi\n" in order
    step(1'b1, 8'h68, 1'b0, 1'b0);
    step(1'b1, 8'h69, 1'b0, 1'b0);
    step(1'b1, 8'h0a, 1'b0, 1'b0);
    chk("t2_in_ch0", 32'(io_uart_in_ch), 32'h68); step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_in_ch1", 32'(io_uart_in_ch), 32'h69); step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_in_ch2", 32'(io_uart_in_ch), 32'h0a); step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_level", 32'(level), 32'd0);
    chk("t2_rd_cnt", rd_cnt, 32'd3);

    // 3: overfill by two
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      if (i == DEPTH - 1) chk("t3_ready_low", 32'(host_ready), 32'd0);
    end
    chk("t3_drop_cnt", drop_cnt, 32'd2);
    chk("t3_level", 32'(level), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_in_ch", 32'(io_uart_in_ch), 32'(8'h30 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t3_level_end", 32'(level), 32'd0);

    // 4: full FIFO, push and read together
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    chk("t4_in_ch_head", 32'(io_uart_in_ch), 32'h50);
    step(1'b1, 8'haa, 1'b1, 1'b0);
    chk("t4_drop_cnt", drop_cnt, 32'd3);
    chk("t4_level", 32'(level), 32'd15);
    chk("t4_in_ch_next", 32'(io_uart_in_ch), 32'h51);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_last_rd", rd_cnt, 32'd35);

    // 5: empty FIFO, push and read together
    chk("t5_in_ch_before", 32'(io_uart_in_ch), 32'hff);
    step(1'b1, 8'h41, 1'b1, 1'b0);
    chk("t5_in_ch_after", 32'(io_uart_in_ch), 32'h41);
    chk("t5_level", 32'(level), 32'd1);
    chk("t5_empty_rd_cnt", empty_rd_cnt, 32'd4);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // 6: flush with a concurrent push and read
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    chk("t6_level_loaded", 32'(level), 32'd5);
    chk("t6_in_ch_flush_cycle", 32'(io_uart_in_ch), 32'h61);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_in_ch", 32'(io_uart_in_ch), 32'hff);
    chk("t6_rd_cnt", rd_cnt, 32'd36);
    chk("t6_drop_cnt", drop_cnt, 32'd3);
    chk("t6_empty_cnt", empty_rd_cnt, 32'd4);
    step(1'b1, 8'h7a, 1'b0, 1'b0);
    chk("t6_post_flush_ch", 32'(io_uart_in_ch), 32'h7a);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // 6b: flush while full with host_valid held is not a drop
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hee, 1'b0, 1'b1);
    chk("t6b_drop_cnt", drop_cnt, 32'd3);
    chk("t6b_level", 32'(level), 32'd0);

    // Asynchronous reset mid-stream
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    chk("ar_level_before", 32'(level), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_level", 32'(level), 32'd0);
    chk("ar_rd_cnt", rd_cnt, 32'd0);
    chk("ar_empty_cnt", empty_rd_cnt, 32'd0);
    chk("ar_drop_cnt", drop_cnt, 32'd0);
    chk("ar_host_ready", 32'(host_ready), 32'd1);
    chk("ar_in_ch", 32'(io_uart_in_ch), 32'hff);
    #10 reset_n = 1'b1;
    @(posedge clock); #1;
    step(1'b1, 8'h5a, 1'b0, 1'b0);
    chk("ar_resume_ch", 32'(io_uart_in_ch), 32'h5a);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ar_resume_rd", rd_cnt, 32'd1);
    chk("ar_resume_empty", empty_rd_cnt, 32'd1);
    @(negedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
